ddr_multi_render_writer: RTL

- Parametrised successor to the single-engine DDR2 write-port controller: merges NUM_CH Mandelbrot render engines into one MCB write port.
- Packs pixels into bursts, issues write commands, and double-buffers frames.
- Sits between the render engines (render_clk domain) and MCB port 0. Drives the frame selector that the read-port/HDMI path uses as its display base.

---
 rtl/ddr_multi_render_writer_pkg.sv | 35 +++
 rtl/ddr_multi_render_writer_rr_arbiter.sv | 57 +++++
 rtl/ddr_multi_render_writer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_multi_render_writer_pkg.sv
// ---------------------------------------------------------------------------
// ddr_multi_render_writer_pkg
// Shared types and constants for the multi-channel render writer:
//   state_t          - writer FSM states
//   MCB_INSTR_WRITE  - MCB command code for a write
//   MCB_MAX_BL       - largest burst the MCB port accepts (words)
//   clog2()          - ceiling log2 usable in parameter expressions
// ---------------------------------------------------------------------------
package ddr_multi_render_writer_pkg;

  typedef enum logic [2:0] {
    WAIT_CAL,
    ARB,
    FILL,
    CMD,
    SWAP
  } state_t;

  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
  localparam int         MCB_MAX_BL      = 64;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ddr_multi_render_writer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_multi_render_writer_rr_arbiter
// Round-robin picker over N requesters. The grant is combinational: the first
// requester strictly after the last granted index, wrapping around. The
// last-grant pointer only moves when 'advance' is high.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req[N]      - request vector
//   advance     - commit the current grant as the new last grant
//   grant       - index of the chosen requester (valid when any=1)
//   any         - at least one request is present
// ---------------------------------------------------------------------------
module ddr_multi_render_writer_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W:0]   cand;

  // Walk from the farthest candidate to the nearest so the nearest requester
  // after last_q overwrites any earlier hit; no early exit needed.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    grant = last_q;
    any   = 1'b0;
    cand  = '0;
    for (int off = N; off >= 1; off--) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant = cand[IDX_W-1:0];
        any   = 1'b1;
      end
    end
  end

  // Starts at N-1 so that index 0 wins the first arbitration after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IDX_W'(N - 1);
    end else if (advance) begin
      last_q <= grant;
    end
  end

endmodule

// File: rtl/ddr_multi_render_writer.sv
// ---------------------------------------------------------------------------
// ddr_multi_render_writer
// Merges NUM_CH render engines into one MCB write port. Each channel owns a
// CH_SPAN_WORDS region inside the back frame; words are packed into bursts of
// up to BURST_LEN, pushed to the write FIFO, then a write command is issued.
// When every channel reports frame done and the write FIFO drains, the
// display frame flips and the regions restart at offset 0.
// Ports:
//   clk, reset                 - render clock, synchronous active-high reset
//   ch_data/ch_valid/ch_ack    - per-channel word stream (valid/ack handshake)
//   ch_frame_done              - per-channel end-of-frame pulse
//   mem_calib_done             - MCB calibration complete
//   wr_full/wr_empty/cmd_full  - MCB FIFO status
//   wr_en/wr_data              - write-FIFO push
//   cmd_en/cmd_instr/cmd_bl/cmd_byte_addr - MCB write command
//   memory_frame, frame_swap   - displayed frame and its toggle pulse
//   overflow                   - sticky: a channel ran past its region
// ---------------------------------------------------------------------------
module ddr_multi_render_writer
  import ddr_multi_render_writer_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter int          BURST_LEN     = 32,
  parameter int          CH_SPAN_WORDS = 131072,
  parameter logic [29:0] FRAME0_BASE   = 30'h0000000,
  parameter logic [29:0] FRAME1_BASE   = 30'h0400000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH*32-1:0] ch_data,
  input  logic [NUM_CH-1:0]    ch_valid,
  output logic [NUM_CH-1:0]    ch_ack,
  input  logic [NUM_CH-1:0]    ch_frame_done,
  input  logic                 mem_calib_done,
  input  logic                 wr_full,
  input  logic                 wr_empty,
  input  logic                 cmd_full,
  output logic                 wr_en,
  output logic [31:0]          wr_data,
  output logic                 cmd_en,
  output logic [2:0]           cmd_instr,
  output logic [5:0]           cmd_bl,
  output logic [29:0]          cmd_byte_addr,
  output logic                 memory_frame,
  output logic                 frame_swap,
  output logic                 overflow
);

  localparam int IDX_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int PTR_W  = clog2(CH_SPAN_WORDS) + 1;
  localparam int BEAT_W = clog2(MCB_MAX_BL) + 1;

  localparam logic [PTR_W-1:0]  PTR_MAX       = PTR_W'(CH_SPAN_WORDS);
  localparam logic [BEAT_W-1:0] BEATS_FULL    = BEAT_W'(BURST_LEN);
  localparam logic [29:0]       CH_SPAN_BYTES = 30'(CH_SPAN_WORDS * 4);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, arb_grant;
  logic              arb_any, arb_advance;
  logic [PTR_W-1:0]  ptr_q [NUM_CH];
  logic [PTR_W-1:0]  start_ptr_q, grant_ptr;
  logic [BEAT_W-1:0] beats_q;
  logic [NUM_CH-1:0] done_q;
  logic              memory_frame_q, overflow_q;
  logic              grant_valid, grant_done;
  logic              fill_ready, xfer, push, swap_go;
  logic [29:0]       target_base;

  // Candidates are channels with data; the done flag only matters once a
  // channel has nothing left to send.
  ddr_multi_render_writer_rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (ch_valid),
    .advance (arb_advance),
    .grant   (arb_grant),
    .any     (arb_any)
  );

  assign grant_valid = ch_valid[grant_q];
  assign grant_done  = done_q[grant_q];
  assign grant_ptr   = ptr_q[grant_q];
  assign fill_ready  = (state_q == FILL) && (beats_q < BEATS_FULL) && !wr_full;
  assign xfer        = fill_ready && grant_valid;
  // A word beyond the region is still consumed so the engine cannot stall,
  // but it is dropped rather than written over the next channel's region.
  assign push        = xfer && (grant_ptr < PTR_MAX);
  assign swap_go     = (state_q == SWAP) && wr_empty;
  assign arb_advance = (state_q == ARB) && arb_any;

  // The writer always fills the frame that is not on display.
  assign target_base = memory_frame_q ? FRAME0_BASE : FRAME1_BASE;

  assign cmd_instr    = MCB_INSTR_WRITE;
  assign memory_frame = memory_frame_q;
  assign overflow     = overflow_q;

  always_comb begin
    state_d       = state_q;
    ch_ack        = '0;
    wr_en         = 1'b0;
    wr_data       = '0;
    cmd_en        = 1'b0;
    cmd_bl        = '0;
    cmd_byte_addr = '0;
    frame_swap    = 1'b0;

    unique case (state_q)
      WAIT_CAL: begin
        if (mem_calib_done) state_d = ARB;
      end

      ARB: begin
        if (arb_any)      state_d = FILL;
        else if (&done_q) state_d = SWAP;
      end

      FILL: begin
        ch_ack[grant_q] = fill_ready;
        wr_en           = push;
        if (push) wr_data = ch_data[32*grant_q +: 32];
        if (beats_q == BEATS_FULL) begin
          state_d = CMD;
        end else if (!grant_valid) begin
          // Empty burst: release the grant. Partial burst: flush only once
          // the channel has declared its frame done, otherwise keep waiting.
          if (beats_q == '0)   state_d = ARB;
          else if (grant_done) state_d = CMD;
        end
      end

      CMD: begin
        cmd_bl        = 6'(beats_q - 1'b1);
        cmd_byte_addr = target_base + (30'(grant_q) * CH_SPAN_BYTES) + (30'(start_ptr_q) << 2);
        if (!cmd_full) begin
          cmd_en  = 1'b1;
          state_d = ARB;
        end
      end

      SWAP: begin
        if (wr_empty) begin
          frame_swap = 1'b1;
          state_d    = ARB;
        end
      end

      default: state_d = WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pointer array is a handful of flops, not a RAM, so it is
      // reset like any other state; a new frame must start at offset 0.
      state_q        <= WAIT_CAL;
      grant_q        <= '0;
      start_ptr_q    <= '0;
      beats_q        <= '0;
      done_q         <= '0;
      memory_frame_q <= 1'b0;
      overflow_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;

      if (arb_advance) begin
        grant_q     <= arb_grant;
        start_ptr_q <= ptr_q[arb_grant];
        beats_q     <= '0;
      end

      if (push) begin
        beats_q          <= beats_q + 1'b1;
        ptr_q[grant_q]   <= grant_ptr + 1'b1;
      end

      if (xfer && !push) overflow_q <= 1'b1;

      if (swap_go) begin
        memory_frame_q <= ~memory_frame_q;
        for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
      end

      // A done pulse coinciding with the swap belongs to the new frame.
      done_q <= (swap_go ? '0 : done_q) | ch_frame_done;
    end
  end

endmodule
